// File: rtl/axis_hist_remapper_dbuf_if.sv
// AXI4-Stream bundle (data, valid, ready, end-of-line, start-of-frame) shared by the
// remapper's input and output sides.
interface axis_hist_remapper_dbuf_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_hist_remapper_dbuf.sv
// Double-buffered LUT pixel remapper: a two-stage lockstep pipeline reads the active bank
// while the host fills the shadow bank; banks swap on the first start-of-frame after a commit.
module axis_hist_remapper_dbuf #(
  parameter int DATA_IN_WIDTH  = 16,
  parameter int LUT_ADDR_WIDTH = 14,
  parameter int DATA_OUT_WIDTH = 8
) (
  input  logic                          axis_aclk,
  input  logic                          axis_aresetn,
  axis_hist_remapper_dbuf_if.slave      s_axis,
  axis_hist_remapper_dbuf_if.master     m_axis,
  input  logic                          bypass,
  input  logic                          lut_we,
  input  logic [LUT_ADDR_WIDTH-1:0]     lut_addr,
  input  logic [DATA_OUT_WIDTH-1:0]     lut_din,
  input  logic                          lut_commit,
  output logic                          lut_commit_pending,
  output logic                          lut_active_bank
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  localparam int RAM_DEPTH = 2 ** (LUT_ADDR_WIDTH + 1);

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic                        w_swap;
  logic                        r_active;

  logic                        w_cen;
  logic                        w_accept;
  logic                        w_clip;
  logic [LUT_ADDR_WIDTH-1:0]   w_addr;
  logic                        w_bank_sel;

  logic                        r_v1;
  logic [LUT_ADDR_WIDTH-1:0]   r_addr1;
  logic                        r_bank1;
  logic                        r_byp1;
  logic [DATA_OUT_WIDTH-1:0]   r_bword1;
  logic                        r_last1;
  logic                        r_user1;

  logic                        r_v2;
  logic                        r_byp2;
  logic [DATA_OUT_WIDTH-1:0]   r_bword2;
  logic                        r_last2;
  logic                        r_user2;
  logic [DATA_OUT_WIDTH-1:0]   r_dout;

  logic [DATA_OUT_WIDTH-1:0]   r_mem [0:RAM_DEPTH-1];

  assign w_cen         = !r_v2 || m_axis.tready;
  assign s_axis.tready = w_cen;
  assign w_accept      = s_axis.tvalid && w_cen;

  // Out-of-range pixels saturate to the last LUT entry instead of wrapping.
  if (DATA_IN_WIDTH > LUT_ADDR_WIDTH) begin : g_clip
    assign w_clip = |s_axis.tdata[DATA_IN_WIDTH-1:LUT_ADDR_WIDTH];
  end else begin : g_noclip
    assign w_clip = 1'b0;
  end

  assign w_addr     = w_clip ? {LUT_ADDR_WIDTH{1'b1}} : s_axis.tdata[LUT_ADDR_WIDTH-1:0];
  assign w_bank_sel = w_swap ? !r_active : r_active;

  // Commit FSM state register and active-bank toggle.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_state  <= ST_IDLE;
      r_active <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_swap) begin
        r_active <= !r_active;
      end
    end
  end

  // Commit FSM next state; a commit seen in IDLE only arms the swap for a later SOF.
  always_comb begin
    w_state_nxt = r_state;
    w_swap      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (lut_commit) begin
          w_state_nxt = ST_PENDING;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PENDING: begin
        if (w_accept && s_axis.tuser) begin
          w_swap      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_PENDING;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Pipeline stages 1 and 2 plus the synchronous RAM read register, all advanced by cen.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_v1     <= 1'b0;
      r_addr1  <= {LUT_ADDR_WIDTH{1'b0}};
      r_bank1  <= 1'b0;
      r_byp1   <= 1'b0;
      r_bword1 <= {DATA_OUT_WIDTH{1'b0}};
      r_last1  <= 1'b0;
      r_user1  <= 1'b0;
      r_v2     <= 1'b0;
      r_byp2   <= 1'b0;
      r_bword2 <= {DATA_OUT_WIDTH{1'b0}};
      r_last2  <= 1'b0;
      r_user2  <= 1'b0;
      r_dout   <= {DATA_OUT_WIDTH{1'b0}};
    end else if (w_cen) begin
      r_v1     <= s_axis.tvalid;
      r_addr1  <= w_addr;
      r_bank1  <= w_bank_sel;
      r_byp1   <= bypass;
      r_bword1 <= w_addr[LUT_ADDR_WIDTH-1 -: DATA_OUT_WIDTH];
      r_last1  <= s_axis.tlast;
      r_user1  <= s_axis.tuser;
      r_v2     <= r_v1;
      r_byp2   <= r_byp1;
      r_bword2 <= r_bword1;
      r_last2  <= r_last1;
      r_user2  <= r_user1;
      r_dout   <= r_mem[{r_bank1, r_addr1}];
    end else begin
      r_v1 <= r_v1;
      r_v2 <= r_v2;
    end
  end

  // Host writes land only in the shadow bank and are frozen while a swap is armed.
  always_ff @(posedge axis_aclk) begin
    if (lut_we && (r_state == ST_IDLE)) begin
      r_mem[{!r_active, lut_addr}] <= lut_din;
    end
  end

  assign m_axis.tvalid      = r_v2;
  assign m_axis.tdata       = r_byp2 ? r_bword2 : r_dout;
  assign m_axis.tlast       = r_last2;
  assign m_axis.tuser       = r_user2;
  assign lut_commit_pending = (r_state == ST_PENDING);
  assign lut_active_bank    = r_active;

endmodule

// File: tb/tb_axis_hist_remapper_dbuf.sv
// Scoreboard bench for axis_hist_remapper_dbuf: a reference LUT/bank model predicts each
// accepted beat, and directed sequences exercise commit, swap, stall, clip, bypass and reset.
module tb_axis_hist_remapper_dbuf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bypass = 1'b0;
  logic        lut_we = 1'b0;
  logic [13:0] lut_addr = 14'd0;
  logic [7:0]  lut_din = 8'd0;
  logic        lut_commit = 1'b0;
  logic        pending;
  logic        active;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [9:0]  sb[$];
  logic [7:0]  last_out = 8'd0;
  logic [7:0]  m_lut [0:1][0:16383];
  logic        m_active = 1'b0;
  logic        m_pending = 1'b0;

  axis_hist_remapper_dbuf_if #(.DATA_WIDTH(16)) s_if ();
  axis_hist_remapper_dbuf_if #(.DATA_WIDTH(8))  m_if ();

  axis_hist_remapper_dbuf #(
    .DATA_IN_WIDTH(16), .LUT_ADDR_WIDTH(14), .DATA_OUT_WIDTH(8)
  ) dut (
    .axis_aclk(clk), .axis_aresetn(rst_n), .s_axis(s_if), .m_axis(m_if),
    .bypass(bypass), .lut_we(lut_we), .lut_addr(lut_addr), .lut_din(lut_din),
    .lut_commit(lut_commit), .lut_commit_pending(pending), .lut_active_bank(active)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] f0(input int i);
    logic [13:0] a;
    a = 14'(i);
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] f1(input int i);
    return 8'(i >> 6);
  endfunction

  task automatic send(input logic [15:0] d, input logic l, input logic u, input logic b);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    s_if.tdata = d; s_if.tlast = l; s_if.tuser = u; s_if.tvalid = 1'b1; bypass = b;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = s_if.tready;
      @(posedge clk); #1;
      n++;
    end
    s_if.tvalid = 1'b0; s_if.tuser = 1'b0; s_if.tlast = 1'b0; bypass = 1'b0;
    check_val("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || m_if.tvalid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic commit();
    lut_commit = 1'b1;
    @(posedge clk); #1;
    lut_commit = 1'b0;
  endtask

  task automatic fill_shadow(input bit use_f0);
    lut_we = 1'b1;
    for (int i = 0; i < 16384; i++) begin
      lut_addr = 14'(i);
      lut_din  = use_f0 ? f0(i) : f1(i);
      @(posedge clk); #1;
    end
    lut_we = 1'b0;
  endtask

  // Reference model: decided at the negedge for the upcoming active edge.
  initial begin : monitor
    logic [13:0] a;
    logic        bk;
    logic [7:0]  e;
    logic        acc;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        m_active  = 1'b0;
        m_pending = 1'b0;
      end else begin
        if (m_if.tvalid && m_if.tready) begin
          if (sb.size() == 0) begin
            check_val("sb_extra_beat", 32'(sb.size()), 32'd1);
          end else begin
            check_val("out_beat", {22'd0, m_if.tdata, m_if.tlast, m_if.tuser}, {22'd0, sb.pop_front()});
          end
          last_out = m_if.tdata;
        end
        acc = s_if.tvalid && s_if.tready;
        if (acc) begin
          a  = (s_if.tdata > 16'd16383) ? 14'h3FFF : s_if.tdata[13:0];
          bk = (m_pending && s_if.tuser) ? !m_active : m_active;
          e  = bypass ? a[13:6] : m_lut[bk][a];
          sb.push_back({e, s_if.tlast, s_if.tuser});
        end
        if (lut_we && !m_pending) m_lut[!m_active][lut_addr] = lut_din;
        if (m_pending && acc && s_if.tuser) begin
          m_active  = !m_active;
          m_pending = 1'b0;
        end else if (!m_pending && lut_commit) begin
          m_pending = 1'b1;
        end
      end
    end
  end

  initial begin : stimulus
    int          k;
    logic        acc;
    logic [9:0]  held;
    m_if.tready = 1'b1;
    s_if.tvalid = 1'b0; s_if.tdata = 16'd0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_tvalid", 32'(m_if.tvalid), 32'd0);
    check_val("rst_tdata", 32'(m_if.tdata), 32'd0);
    check_val("rst_tlast_tuser", {30'd0, m_if.tlast, m_if.tuser}, 32'd0);
    check_val("rst_active", 32'(active), 32'd0);
    check_val("rst_pending", 32'(pending), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Bank 1 = i>>6, commit, first frame swaps to it.
    fill_shadow(1'b0);
    commit();
    check_val("commit_pending", 32'(pending), 32'd1);
    send(16'd0, 1'b0, 1'b1, 1'b0);
    send(16'd64, 1'b0, 1'b0, 1'b0);
    send(16'd16383, 1'b1, 1'b0, 1'b0);
    drain();
    check_val("f1_max", 32'(last_out), 32'd255);
    check_val("swap1_active", 32'(active), 32'd1);
    check_val("swap1_pending", 32'(pending), 32'd0);

    // Bank 0 = i^0x5A (entry 16383 = 0xA5); clip and bypass.
    fill_shadow(1'b1);
    commit();
    send(16'hFFFF, 1'b0, 1'b1, 1'b0);
    drain();
    check_val("clip_lut", 32'(last_out), 32'hA5);
    send(16'hFFFF, 1'b1, 1'b0, 1'b1);
    drain();
    check_val("clip_bypass", 32'(last_out), 32'hFF);
    check_val("swap2_active", 32'(active), 32'd0);

    // Mid-frame commit: old bank until the next SOF, pending drops right after that beat.
    send(16'd1000, 1'b0, 1'b1, 1'b0);
    commit();
    send(16'd2000, 1'b0, 1'b0, 1'b0);
    drain();
    check_val("midframe_old_bank", 32'(last_out), 32'h8A);
    s_if.tdata = 16'd2000; s_if.tuser = 1'b1; s_if.tlast = 1'b0; s_if.tvalid = 1'b1;
    @(negedge clk);
    check_val("pre_sof_pending", 32'(pending), 32'd1);
    check_val("pre_sof_ready", 32'(s_if.tready), 32'd1);
    @(posedge clk); #1;
    s_if.tvalid = 1'b0; s_if.tuser = 1'b0;
    check_val("post_sof_pending", 32'(pending), 32'd0);
    check_val("post_sof_active", 32'(active), 32'd1);
    drain();
    check_val("sof_new_bank", 32'(last_out), 32'd31);

    // Output stall: pipe fills with two beats then backpressures.
    m_if.tready = 1'b0;
    k = 0;
    held = 10'd0;
    s_if.tdata = 16'd300; s_if.tuser = 1'b1; s_if.tlast = 1'b0; s_if.tvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      acc = s_if.tready;
      @(posedge clk); #1;
      if (acc) begin
        k++;
        s_if.tdata = 16'(300 + k * 64); s_if.tuser = 1'b0; s_if.tlast = (k == 3);
      end
      if (c == 2) held = {m_if.tdata, m_if.tlast, m_if.tuser};
    end
    check_val("stall_accepted", 32'(k), 32'd2);
    check_val("stall_tready", 32'(s_if.tready), 32'd0);
    check_val("stall_tvalid", 32'(m_if.tvalid), 32'd1);
    check_val("stall_hold", {22'd0, m_if.tdata, m_if.tlast, m_if.tuser}, {22'd0, held});
    m_if.tready = 1'b1;
    send(16'(300 + 2 * 64), 1'b0, 1'b0, 1'b0);
    send(16'(300 + 3 * 64), 1'b1, 1'b0, 1'b0);
    drain();
    check_val("stall_last", 32'(last_out), 32'(f1(300 + 3 * 64)));

    // Writes while pending are dropped.
    commit();
    lut_we = 1'b1; lut_addr = 14'd100; lut_din = 8'h33;
    @(posedge clk); #1;
    lut_we = 1'b0;
    send(16'd100, 1'b0, 1'b1, 1'b0);
    drain();
    check_val("pending_write_ignored", 32'(last_out), 32'h3E);
    check_val("swap3_active", 32'(active), 32'd0);

    // Commit coincident with SOF: no swap until the following SOF.
    s_if.tdata = 16'd64; s_if.tuser = 1'b1; s_if.tlast = 1'b0; s_if.tvalid = 1'b1;
    lut_commit = 1'b1;
    @(negedge clk);
    check_val("sof_commit_ready", 32'(s_if.tready), 32'd1);
    @(posedge clk); #1;
    lut_commit = 1'b0; s_if.tvalid = 1'b0; s_if.tuser = 1'b0;
    check_val("sof_commit_no_swap", 32'(active), 32'd0);
    check_val("sof_commit_pending", 32'(pending), 32'd1);
    drain();
    check_val("sof_commit_old", 32'(last_out), 32'h1A);
    send(16'd64, 1'b0, 1'b1, 1'b0);
    drain();
    check_val("sof_commit_later_swap", 32'(last_out), 32'd1);

    // Write and commit in the same cycle: the write lands.
    lut_we = 1'b1; lut_addr = 14'd200; lut_din = 8'h77; lut_commit = 1'b1;
    @(posedge clk); #1;
    lut_we = 1'b0; lut_commit = 1'b0;
    send(16'd200, 1'b1, 1'b1, 1'b0);
    drain();
    check_val("we_commit_same", 32'(last_out), 32'h77);

    // Reset mid-frame with beats in flight and a commit armed.
    commit();
    send(16'd64, 1'b0, 1'b1, 1'b0);
    drain();
    commit();
    m_if.tready = 1'b0;
    send(16'd128, 1'b0, 1'b0, 1'b0);
    send(16'd192, 1'b1, 1'b0, 1'b0);
    check_val("prerst_tvalid", 32'(m_if.tvalid), 32'd1);
    check_val("prerst_active", 32'(active), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_tvalid", 32'(m_if.tvalid), 32'd0);
    check_val("rst_mid_active", 32'(active), 32'd0);
    check_val("rst_mid_pending", 32'(pending), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_if.tready = 1'b1;
    send(16'd64, 1'b0, 1'b1, 1'b0);
    drain();
    check_val("lut_kept_after_rst", 32'(last_out), 32'h1A);
    check_val("post_rst_active", 32'(active), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
